// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, absorbs the 1-cycle synchronous memory
// read latency and presents instruction, PC, PC+4 and a valid flag to decode.
module fetch_stage #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   StallF,
    input  logic                   PCSrcE,
    input  logic [ADDR_WIDTH-1:0]  PCTargetE,
    output logic [ADDR_WIDTH-1:0]  PCF,
    input  logic [INSTR_WIDTH-1:0] InstrF,
    output logic [INSTR_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0]  PCD,
    output logic [ADDR_WIDTH-1:0]  PCPlus4D,
    output logic                   ValidD
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0]  pcf_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] hold_q;
    logic                   hold_v_q;
    logic [ADDR_WIDTH-1:0]  target_aligned;

    // Target low bits are dropped; misalignment is reported elsewhere.
    assign target_aligned = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q    <= RESET_PC;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            hold_q   <= NOP_INSTR;
            hold_v_q <= 1'b0;
        end else if (PCSrcE) begin
            pcf_q    <= target_aligned;
            valid_q  <= 1'b0;
            hold_v_q <= 1'b0;
        end else if (StallF) begin
            // Memory re-reads PCF while stalled, so the live data is captured only once.
            if (!hold_v_q) begin
                hold_q   <= InstrF;
                hold_v_q <= 1'b1;
            end
        end else begin
            pcf_q    <= pcf_q + PC_STEP;
            pc_q     <= pcf_q;
            valid_q  <= 1'b1;
            hold_v_q <= 1'b0;
        end
    end

    assign PCF      = pcf_q;
    assign ValidD   = valid_q;
    assign InstrD   = !valid_q ? NOP_INSTR : (hold_v_q ? hold_q : InstrF);
    assign PCD      = pc_q;
    assign PCPlus4D = pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic,
// checked every cycle against an abstract "decode sees mem[PCD]" model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] PCF;
    logic [31:0] InstrF = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Abstract model: next fetch address, and the PC/validity of what decode should see.
    logic [31:0] m_pcf;
    logic [31:0] m_pc;
    logic        m_valid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .PCF       (PCF),
        .InstrF    (InstrF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0001;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) InstrF <= memf(PCF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pcf   = 32'h0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic p, input logic [31:0] t);
        if (r) model_reset();
        else if (p) begin
            m_pcf   = t & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!s) begin
            m_pc    = m_pcf;
            m_pcf   = m_pcf + 32'd4;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
        chk("PCF", PCF, m_pcf);
        chk("InstrD", InstrD, m_valid ? memf(m_pc) : NOP);
        if (m_valid || rst) begin
            chk("PCD", PCD, m_pc);
            chk("PCPlus4D", PCPlus4D, m_pc + 32'd4);
        end
    endtask

    // Drive inputs, let one edge pass, then check at the falling edge.
    task automatic step(input logic r, input logic s, input logic p, input logic [31:0] t);
        rst = r; StallF = s; PCSrcE = p; PCTargetE = t;
        @(posedge clk);
        model_edge(r, s, p, t);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h100);
        chk("rst_InstrD", InstrD, NOP);
        chk("rst_PCPlus4D", PCPlus4D, 32'h4);

        // Start-up sequence
        step(0, 0, 0, 0);
        chk("t1_InstrD", InstrD, memf(32'h0));
        chk("t1_PCF", PCF, 32'h4);
        step(0, 0, 0, 0);
        chk("t1_InstrD2", InstrD, memf(32'h4));
        chk("t1_PCPlus4D", PCPlus4D, 32'h8);
        chk("t1_PCF2", PCF, 32'h8);

        // Two-cycle stall holding I1, then I2 without skip
        step(0, 1, 0, 0);
        chk("t2_hold1", InstrD, memf(32'h4));
        step(0, 1, 0, 0);
        chk("t2_hold2", InstrD, memf(32'h4));
        chk("t2_PCF", PCF, 32'h8);
        step(0, 0, 0, 0);
        chk("t2_next", InstrD, memf(32'h8));
        chk("t2_PCD", PCD, 32'h8);

        // Redirect to 0x40
        step(0, 0, 1, 32'h40);
        chk("t3_bubble", InstrD, NOP);
        chk("t3_PCF", PCF, 32'h40);
        step(0, 0, 0, 0);
        chk("t3_target", InstrD, memf(32'h40));
        chk("t3_PCD", PCD, 32'h40);

        // Redirect beats stall; low target bits dropped
        step(0, 1, 1, 32'h23);
        chk("t4_PCF", PCF, 32'h20);
        step(0, 0, 0, 0);
        chk("t4_target", InstrD, memf(32'h20));

        // Asynchronous reset in the middle of a stall
        step(0, 1, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t5_ValidD", {31'b0, ValidD}, 32'h0);
        chk("t5_PCF", PCF, 32'h0);
        chk("t5_InstrD", InstrD, NOP);
        chk("t5_PCD", PCD, 32'h0);
        @(negedge clk);
        check_model();
        step(0, 0, 0, 0);
        chk("t5_restart", InstrD, memf(32'h0));

        // Address wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("t6_InstrD", InstrD, memf(32'hFFFF_FFFC));
        chk("t6_PCPlus4D", PCPlus4D, 32'h0);
        chk("t6_PCF", PCF, 32'h0);
        step(0, 0, 0, 0);
        chk("t6_PCD", PCD, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, p;
            logic [31:0] t;
            r = ($urandom_range(63) == 0);
            s = ($urandom_range(2) == 0);
            p = ($urandom_range(7) == 0);
            t = $urandom();
            step(r, s, p, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
